// File: rtl/mem_bus_controller.sv
// Memory-map controller between the CPU data port and the ROM, RAM and GPIO register.
// Decodes requests, rebases them to region offsets and sequences wait states and responses.
module mem_bus_controller #(
    parameter int              ADDR_W    = 32,
    parameter int              DATA_W    = 32,
    parameter longint unsigned ROM_BASE  = 0,
    parameter longint unsigned ROM_SIZE  = 152100,
    parameter longint unsigned RAM_BASE  = 152100,
    parameter longint unsigned RAM_SIZE  = 153636,
    parameter longint unsigned GPIO_ADDR = 305736,
    parameter int              GPIO_W    = 8,
    parameter int              ROM_LAT   = 1,
    parameter int              RAM_LAT   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wd,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rd,
    output logic              resp_err,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_rd,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wd,
    input  logic [DATA_W-1:0] ram_rd,
    output logic [GPIO_W-1:0] gpio,
    output logic              gpio_en
);

    localparam int MAX_LAT = (ROM_LAT > RAM_LAT) ? ROM_LAT : RAM_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    // Offsets wrap below the base, so one unsigned compare per region tests both bounds.
    localparam bit ROM_RAM_OVL = (ROM_SIZE != 0) && (RAM_SIZE != 0) &&
                                 (ROM_BASE < RAM_BASE + RAM_SIZE) &&
                                 (RAM_BASE < ROM_BASE + ROM_SIZE);
    localparam bit GPIO_OVL    = (GPIO_ADDR - ROM_BASE < ROM_SIZE) ||
                                 (GPIO_ADDR - RAM_BASE < RAM_SIZE);
    localparam bit BAD_CFG     = (GPIO_W > DATA_W) || (ROM_LAT < 1) || (RAM_LAT < 1) ||
                                 (ADDR_W > 64);

    generate
        if (ROM_RAM_OVL || GPIO_OVL || BAD_CFG) begin : g_bad_params
            $error("mem_bus_controller: overlapping regions or invalid parameters");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t            state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic              lat_we, lat_we_d;
    logic              lat_rom, lat_rom_d;
    logic              req_ready_d, resp_valid_d, resp_err_d, ram_we_d, gpio_en_d;
    logic [DATA_W-1:0] resp_rd_d, ram_wd_d;
    logic [ADDR_W-1:0] rom_addr_d, ram_addr_d;
    logic [GPIO_W-1:0] gpio_d;

    logic [63:0] addr_ext, rom_rel, ram_rel;
    logic        hit_rom, hit_ram, hit_gpio;

    assign addr_ext = 64'(req_addr);
    assign rom_rel  = addr_ext - ROM_BASE;
    assign ram_rel  = addr_ext - RAM_BASE;
    assign hit_rom  = rom_rel < ROM_SIZE;
    assign hit_ram  = ram_rel < RAM_SIZE;
    assign hit_gpio = addr_ext == GPIO_ADDR;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            lat_we     <= 1'b0;
            lat_rom    <= 1'b0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rd    <= '0;
            resp_err   <= 1'b0;
            rom_addr   <= '0;
            ram_addr   <= '0;
            ram_wd     <= '0;
            ram_we     <= 1'b0;
            gpio       <= '0;
            gpio_en    <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            lat_we     <= lat_we_d;
            lat_rom    <= lat_rom_d;
            req_ready  <= req_ready_d;
            resp_valid <= resp_valid_d;
            resp_rd    <= resp_rd_d;
            resp_err   <= resp_err_d;
            rom_addr   <= rom_addr_d;
            ram_addr   <= ram_addr_d;
            ram_wd     <= ram_wd_d;
            ram_we     <= ram_we_d;
            gpio       <= gpio_d;
            gpio_en    <= gpio_en_d;
        end
    end

    // Every output is registered, so this block computes the value each one takes next cycle.
    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        lat_we_d     = lat_we;
        lat_rom_d    = lat_rom;
        resp_valid_d = 1'b0;
        resp_rd_d    = resp_rd;
        resp_err_d   = resp_err;
        rom_addr_d   = rom_addr;
        ram_addr_d   = ram_addr;
        ram_wd_d     = ram_wd;
        ram_we_d     = 1'b0;
        gpio_d       = gpio;
        gpio_en_d    = 1'b0;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    lat_we_d  = req_we;
                    lat_rom_d = hit_rom;
                    if (hit_rom && !req_we) begin
                        rom_addr_d = rom_rel[ADDR_W-1:0];
                        cnt_d      = CNT_W'(ROM_LAT);
                        state_d    = WAIT;
                    end else if (!hit_rom && hit_ram) begin
                        ram_addr_d = ram_rel[ADDR_W-1:0];
                        cnt_d      = CNT_W'(RAM_LAT);
                        state_d    = WAIT;
                        if (req_we) begin
                            ram_we_d = 1'b1;
                            ram_wd_d = req_wd;
                        end
                    end else begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_rd_d    = '0;
                        resp_err_d   = 1'b0;
                        if (!hit_rom && hit_gpio) begin
                            if (req_we) begin
                                gpio_d    = req_wd[GPIO_W-1:0];
                                gpio_en_d = 1'b1;
                            end else begin
                                resp_rd_d = DATA_W'(gpio);
                            end
                        end else begin
                            resp_err_d = 1'b1;
                        end
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt - 1'b1;
                if (cnt == CNT_W'(1)) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    if (lat_we) begin
                        resp_rd_d = '0;
                    end else if (lat_rom) begin
                        resp_rd_d = rom_rd;
                    end else begin
                        resp_rd_d = ram_rd;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        req_ready_d = (state_d == IDLE);
    end

endmodule
